dw_sync_feeder: RTL and testbench
=================================

DW_SYNC_FEEDER -- requirements
Module: dw_sync_feeder

Interface
REQ-001 Parameter WIDTH, default 8, payload width (1..1024); SHALL match the downstream data_sync width.
REQ-002 Parameter DEPTH, default 4, queue depth in words (2..16).
REQ-003 Parameter TMO_CYCLES, default 64, done-wait timeout in cycles (2..255); SHALL be used only when the Configuration macro is defined.
REQ-004 clk_s  in  1  single clock; all logic SHALL be rising-edge.
REQ-005 rst_s_n  in  1  asynchronous, active-low reset.
REQ-006 init_s_n  in  1  synchronous, active-low clear.
REQ-007 push_s  in  1  producer write strobe.
REQ-008 push_data_s  in  WIDTH  producer word.
REQ-009 push_ready_s  out  1  high when count_s < DEPTH.
REQ-010 count_s  out  clog2(DEPTH+1)  words held, including the word in flight.
REQ-011 overflow_s  out  1  one-cycle pulse when a push is dropped.
REQ-012 sync_empty_s  in  1  downstream data_sync empty_s.
REQ-013 sync_done_s  in  1  downstream data_sync done_s.
REQ-014 send_s  out  1  send strobe to data_sync.
REQ-015 data_s  out  WIDTH  word to data_sync.
REQ-016 busy_s  out  1  high when the FSM is not in IDLE.
REQ-017 timeout_s  out  1  one-cycle timeout pulse; the port SHALL always exist.

Function
REQ-018 Queue: circular buffer with read and write pointers; pointers SHALL wrap from DEPTH-1 to 0.
REQ-019 Push acceptance: push_s=1 with count_s<DEPTH SHALL store the word and increment count_s at that edge.
REQ-020 Dropped push: push_s=1 with count_s==DEPTH SHALL discard the word and pulse overflow_s the next cycle; state SHALL be unchanged.
REQ-021 Full-queue push with pop: a pop in the same cycle SHALL NOT make room for that push; the push SHALL be dropped.
REQ-022 Simultaneous push and pop when not full: count_s SHALL be unchanged and both pointers SHALL advance.
REQ-023 FSM states and transitions:
  - IDLE -> SEND when count_s>0 and sync_empty_s=1.
  - SEND -> WAIT unconditionally after one cycle.
  - WAIT -> IDLE on sync_done_s=1.
REQ-024 Send strobe: send_s SHALL be registered and high exactly while in SEND (one cycle per word).
REQ-025 Data load: data_s SHALL load the head word on the edge entering SEND and hold it until the next SEND.
REQ-026 Latency: with an empty queue, idle FSM and sync_empty_s=1, send_s SHALL rise on the first edge after the accepting edge.
REQ-027 Pop: sync_done_s=1 in WAIT SHALL pop the head (read pointer +1, count_s -1) on that edge.
REQ-028 sync_done_s in IDLE or SEND SHALL be ignored.
REQ-029 Back-to-back: after a WAIT->IDLE transition, the next SEND SHALL occur no earlier than one IDLE cycle later.
REQ-030 In-order delivery: words SHALL be delivered in push order, with no loss except dropped pushes.

Reset
REQ-031 With rst_s_n=0, the block SHALL asynchronously force:
  - FSM to IDLE and pointers to 0;
  - count_s, send_s, data_s, overflow_s, timeout_s, busy_s to 0;
  - push_ready_s to 1.
REQ-032 init_s_n=0 SHALL apply the same values synchronously and SHALL override push_s and sync_done_s in that cycle.
REQ-033 Reset or init asserted in SEND or WAIT SHALL discard all queued and in-flight words.
REQ-034 Queue storage SHALL NOT require reset.

Configuration
REQ-035 Macro DW_SYNC_FEEDER_TIMEOUT_EN.
REQ-036 Defined: an 8-bit counter SHALL clear on entering WAIT and increment each WAIT cycle. At TMO_CYCLES without sync_done_s, the block SHALL:
  - pulse timeout_s for one cycle;
  - return to IDLE without popping, so the head is resent.
REQ-037 Undefined: there SHALL be no counter, timeout_s SHALL be tied 0, and WAIT SHALL exit only on sync_done_s.

Verification
REQ-038 Reset, then push 0xA5 with sync_empty_s=1 -> send_s pulse one edge later with data_s=0xA5, busy_s=1, count_s=1; sync_done_s -> count_s=0, busy_s=0.
REQ-039 DEPTH=4: push 0x01..0x05 with sync_empty_s=0 -> count_s=4, push_ready_s=0, overflow_s pulses once for 0x05; release -> delivery order 0x01..0x04.
REQ-040 Queue full in WAIT: push and sync_done_s on the same edge -> push dropped, overflow_s=1, count_s=3.
REQ-041 init_s_n low during WAIT with 3 words queued -> next edge: count_s=0, FSM IDLE, send_s=0; a later sync_done_s causes no pop.
REQ-042 Macro defined, TMO_CYCLES=8, sync_done_s held 0 -> timeout_s pulse after 8 WAIT cycles, then send_s again with the same data_s.

Source files
------------

// File: rtl/dw_sync_feeder.sv
// dw_sync_feeder: queues producer words and hands them one at a time to a data_sync block
// Optional feature macro: DW_SYNC_FEEDER_TIMEOUT_EN (done-wait timeout with resend of the head word)
// Ports:
//    clk_s         rising-edge clock
//    rst_s_n       asynchronous active-low reset
//    init_s_n      synchronous active-low clear
//    push_s        producer write strobe
//    push_data_s   producer word
//    push_ready_s  queue has room
//    count_s       words held, including the word in flight
//    overflow_s    one-cycle pulse for a dropped push
//    sync_empty_s  downstream empty status
//    sync_done_s   downstream done status
//    send_s        one-cycle send strobe to downstream
//    data_s        word presented to downstream
//    busy_s        FSM not idle
//    timeout_s     one-cycle pulse when the done wait expires
module dw_sync_feeder #(
   parameter int WIDTH      = 8,
   parameter int DEPTH      = 4,
   parameter int TMO_CYCLES = 64
) (
   input  logic                         clk_s,
   input  logic                         rst_s_n,
   input  logic                         init_s_n,
   input  logic                         push_s,
   input  logic [WIDTH-1:0]             push_data_s,
   output logic                         push_ready_s,
   output logic [$clog2(DEPTH+1)-1:0]   count_s,
   output logic                         overflow_s,
   input  logic                         sync_empty_s,
   input  logic                         sync_done_s,
   output logic                         send_s,
   output logic [WIDTH-1:0]             data_s,
   output logic                         busy_s,
   output logic                         timeout_s
);
   localparam int CW = $clog2(DEPTH+1);
   localparam int PW = $clog2(DEPTH);
   typedef enum logic [1:0] {IDLE, SEND, WAIT} st_t;
   st_t              r_st, w_nst;
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_rd, r_wr;
   logic [CW-1:0]    r_cnt;
   logic             r_send, r_ovf, r_tmo;
   logic [WIDTH-1:0] r_data;
   logic             w_full, w_push, w_pop, w_to, w_load, w_busy;
   // a pop in the same cycle never frees a slot for a push into a full queue
   assign w_full = r_cnt == CW'(DEPTH);
   assign w_push = push_s & ~w_full;
   assign w_pop  = (r_st == WAIT) & sync_done_s;
`ifdef DW_SYNC_FEEDER_TIMEOUT_EN
   logic [7:0] r_wc;
   // expires on the TMO_CYCLES-th WAIT cycle; a done in that cycle still wins
   assign w_to = (r_st == WAIT) & ~sync_done_s & (r_wc == 8'(TMO_CYCLES-1));
   always_ff @(posedge clk_s or negedge rst_s_n)
      if (!rst_s_n)
         r_wc <= '0;
      else if (!init_s_n)
         r_wc <= '0;
      else
         r_wc <= (r_st == SEND) ? 8'd0 : (r_st == WAIT) ? r_wc + 8'd1 : r_wc;
`else
   logic [7:0] w_unused_tmo;
   assign w_unused_tmo = 8'(TMO_CYCLES);
   assign w_to = 1'b0;
`endif
   always_ff @(posedge clk_s or negedge rst_s_n)
      if (!rst_s_n)
         r_st <= IDLE;
      else if (!init_s_n)
         r_st <= IDLE;
      else
         r_st <= w_nst;
   always_comb begin
      w_nst = (r_st == IDLE) ? ((r_cnt != '0 && sync_empty_s) ? SEND : IDLE) :
              (r_st == SEND) ? WAIT :
              (w_pop || w_to) ? IDLE : WAIT;
   end
   always_comb begin
      w_load = (r_st == IDLE) && (w_nst == SEND);
      w_busy = r_st != IDLE;
   end
   always_ff @(posedge clk_s)
      if (w_push && init_s_n)
         r_mem[r_wr] <= push_data_s;
   always_ff @(posedge clk_s or negedge rst_s_n)
      if (!rst_s_n) begin
         r_rd   <= '0;
         r_wr   <= '0;
         r_cnt  <= '0;
         r_send <= 1'b0;
         r_data <= '0;
         r_ovf  <= 1'b0;
         r_tmo  <= 1'b0;
      end else if (!init_s_n) begin
         r_rd   <= '0;
         r_wr   <= '0;
         r_cnt  <= '0;
         r_send <= 1'b0;
         r_data <= '0;
         r_ovf  <= 1'b0;
         r_tmo  <= 1'b0;
      end else begin
         r_wr   <= w_push ? ((r_wr == PW'(DEPTH-1)) ? '0 : r_wr + 1'b1) : r_wr;
         r_rd   <= w_pop ? ((r_rd == PW'(DEPTH-1)) ? '0 : r_rd + 1'b1) : r_rd;
         r_cnt  <= r_cnt + CW'(w_push) - CW'(w_pop);
         r_send <= w_load;
         r_data <= w_load ? r_mem[r_rd] : r_data;
         r_ovf  <= push_s & w_full;
         r_tmo  <= w_to;
      end
   assign push_ready_s = ~w_full;
   assign count_s      = r_cnt;
   assign overflow_s   = r_ovf;
   assign send_s       = r_send;
   assign data_s       = r_data;
   assign busy_s       = w_busy;
   assign timeout_s    = r_tmo;
endmodule

// File: tb/tb_dw_sync_feeder.sv
// tb_dw_sync_feeder: directed bench with a queue-level reference model for dw_sync_feeder
module tb_dw_sync_feeder;
   localparam int W = 8;
   localparam int D = 4;
   localparam int T = 8;
   logic         clk_s = 1'b0;
   logic         rst_s_n = 1'b0;
   logic         init_s_n = 1'b1;
   logic         push_s = 1'b0;
   logic [W-1:0] push_data_s = '0;
   logic         sync_empty_s = 1'b1;
   logic         sync_done_s = 1'b0;
   logic         push_ready_s, overflow_s, send_s, busy_s, timeout_s;
   logic [2:0]   count_s;
   logic [W-1:0] data_s;
   int checks = 0;
   int errors = 0;
   int nsend = 0;
   int ntmo = 0;
   logic [W-1:0] dlv[$];
   dw_sync_feeder #(.WIDTH(W), .DEPTH(D), .TMO_CYCLES(T)) dut (
      .clk_s(clk_s), .rst_s_n(rst_s_n), .init_s_n(init_s_n), .push_s(push_s),
      .push_data_s(push_data_s), .push_ready_s(push_ready_s), .count_s(count_s),
      .overflow_s(overflow_s), .sync_empty_s(sync_empty_s), .sync_done_s(sync_done_s),
      .send_s(send_s), .data_s(data_s), .busy_s(busy_s), .timeout_s(timeout_s));
   always #5 clk_s = ~clk_s;
   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
      end
   endtask
   // reference model: held words as a queue, handshake phase 0=idle 1=send 2=wait
   logic [W-1:0] mq[$];
   int           mph = 0;
   int           mwait = 0;
   logic [W-1:0] mdata = '0;
   bit           movf = 0;
   bit           mtmo = 0;
   always @(posedge clk_s or negedge rst_s_n) begin
      bit full, pop, to;
      if (!rst_s_n || !init_s_n) begin
         mq.delete();
         mph = 0; mwait = 0; mdata = '0; movf = 0; mtmo = 0;
      end else begin
         full = mq.size() == D;
         pop = (mph == 2) && sync_done_s;
         to = 0;
`ifdef DW_SYNC_FEEDER_TIMEOUT_EN
         to = (mph == 2) && !sync_done_s && (mwait == T - 1);
`endif
         movf = push_s && full;
         mtmo = to;
         if (mph == 0) begin
            if (mq.size() > 0 && sync_empty_s) begin
               mph = 1;
               mdata = mq[0];
            end
         end else if (mph == 1) begin
            mph = 2;
            mwait = 0;
         end else if (pop || to)
            mph = 0;
         else
            mwait++;
         if (pop) void'(mq.pop_front());
         if (push_s && !full) mq.push_back(push_data_s);
      end
   end
   always @(negedge clk_s) begin
      chk("count", 32'(count_s), 32'(mq.size()));
      chk("ready", 32'(push_ready_s), 32'(mq.size() < D));
      chk("send", 32'(send_s), 32'(mph == 1));
      chk("busy", 32'(busy_s), 32'(mph != 0));
      chk("data", 32'(data_s), 32'(mdata));
      chk("overflow", 32'(overflow_s), 32'(movf));
      chk("timeout", 32'(timeout_s), 32'(mtmo));
      if (send_s === 1'b1) begin
         dlv.push_back(data_s);
         nsend++;
      end
      if (timeout_s === 1'b1) ntmo++;
   end
   task automatic tick();
      @(posedge clk_s);
      #1;
   endtask
   initial begin
      tick(); tick();
      chk("rst_count", 32'(count_s), 0);
      chk("rst_ready", 32'(push_ready_s), 1);
      chk("rst_busy", 32'(busy_s), 0);
      rst_s_n = 1'b1;
      push_s = 1'b1; push_data_s = 8'hA5; tick();
      push_s = 1'b0;
      chk("a5_count", 32'(count_s), 1);
      chk("a5_nosend", 32'(send_s), 0);
      tick();
      chk("a5_send", 32'(send_s), 1);
      chk("a5_data", 32'(data_s), 32'hA5);
      chk("a5_busy", 32'(busy_s), 1);
      tick();
      chk("a5_wait_send", 32'(send_s), 0);
      sync_done_s = 1'b1; tick(); sync_done_s = 1'b0;
      chk("a5_popped", 32'(count_s), 0);
      chk("a5_idle", 32'(busy_s), 0);
      sync_empty_s = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         push_s = 1'b1; push_data_s = W'(i); tick();
         if (i == 4) begin
            chk("fill_count", 32'(count_s), 4);
            chk("fill_ready", 32'(push_ready_s), 0);
            chk("fill_noovf", 32'(overflow_s), 0);
         end
      end
      chk("ovf_pulse", 32'(overflow_s), 1);
      chk("ovf_count", 32'(count_s), 4);
      push_s = 1'b0; tick();
      chk("ovf_clear", 32'(overflow_s), 0);
      dlv.delete();
      sync_empty_s = 1'b1; sync_done_s = 1'b1;
      repeat (30) tick();
      sync_done_s = 1'b0;
      chk("order_n", 32'(dlv.size()), 4);
      for (int k = 0; k < 4; k++)
         chk("order_word", (k < dlv.size()) ? 32'(dlv[k]) : 32'hFFFF, 32'(k + 1));
      for (int i = 0; i < 4; i++) begin
         push_s = 1'b1; push_data_s = W'(8'h10 + i); tick();
      end
      chk("full_wait_count", 32'(count_s), 4);
      chk("full_wait_busy", 32'(busy_s), 1);
      push_data_s = 8'h99; sync_done_s = 1'b1; tick();
      push_s = 1'b0; sync_done_s = 1'b0;
      chk("fullpop_count", 32'(count_s), 3);
      chk("fullpop_ovf", 32'(overflow_s), 1);
      tick();
      chk("resend_send", 32'(send_s), 1);
      chk("resend_data", 32'(data_s), 32'h11);
      tick();
      chk("init_pre_count", 32'(count_s), 3);
      init_s_n = 1'b0; tick(); init_s_n = 1'b1;
      chk("init_count", 32'(count_s), 0);
      chk("init_busy", 32'(busy_s), 0);
      chk("init_send", 32'(send_s), 0);
      sync_done_s = 1'b1; tick(); sync_done_s = 1'b0;
      chk("init_nopop", 32'(count_s), 0);
      push_s = 1'b1; push_data_s = 8'h21; tick();
      push_s = 1'b0; tick(); tick();
      push_s = 1'b1; push_data_s = 8'h22; sync_done_s = 1'b1; tick();
      push_s = 1'b0; sync_done_s = 1'b0;
      chk("pushpop_count", 32'(count_s), 1);
      tick();
      chk("pushpop_send", 32'(send_s), 1);
      chk("pushpop_data", 32'(data_s), 32'h22);
      tick();
      sync_done_s = 1'b1; tick(); sync_done_s = 1'b0;
      chk("pushpop_drain", 32'(count_s), 0);
      nsend = 0; ntmo = 0;
      push_s = 1'b1; push_data_s = 8'h77; tick();
      push_s = 1'b0;
      repeat (12) tick();
`ifdef DW_SYNC_FEEDER_TIMEOUT_EN
      chk("tmo_pulses", 32'(ntmo), 1);
      chk("tmo_sends", 32'(nsend), 2);
`else
      chk("tmo_pulses", 32'(ntmo), 0);
      chk("tmo_sends", 32'(nsend), 1);
`endif
      chk("tmo_data", 32'(data_s), 32'h77);
      chk("tmo_busy", 32'(busy_s), 1);
      chk("tmo_count", 32'(count_s), 1);
      sync_done_s = 1'b1; tick(); sync_done_s = 1'b0;
      tick();
      chk("tmo_drain", 32'(count_s), 0);
      push_s = 1'b1; push_data_s = 8'h5A; tick();
      push_s = 1'b0; tick(); tick();
      chk("arst_pre_busy", 32'(busy_s), 1);
      #1 rst_s_n = 1'b0;
      #1;
      chk("arst_count", 32'(count_s), 0);
      chk("arst_busy", 32'(busy_s), 0);
      chk("arst_ready", 32'(push_ready_s), 1);
      chk("arst_data", 32'(data_s), 0);
      tick();
      rst_s_n = 1'b1;
      tick(); tick();
      chk("arst_after", 32'(count_s), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
